// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - memory/writeback stage: data-memory handshake, bus wait, register write-back and operand bypass
module mem_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] iAluOut,
  input  logic [15:0] iData2,
  input  logic [3:0]  iDest,
  input  logic        iAlutoReg,
  input  logic        iMemtoReg,
  input  logic        iBustoReg,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [3:0]  iSr1,
  input  logic [3:0]  iSr2,
  output logic [1:0]  oForward,
  output logic        oStall,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [15:0] oMemAddr,
  output logic [15:0] oMemWData,
  input  logic        iMemAck,
  input  logic [15:0] iMemRData,
  input  logic [15:0] iBusData,
  input  logic        iBusValid,
  output logic        oRegWe,
  output logic [3:0]  oRegDest,
  output logic [15:0] oWriteBackData
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, BUS_WAIT, COMPLETE} state_t;

  state_t     r_state;
  logic [3:0] r_dest;
  logic       r_load_wb;

  logic w_mem_op;
  logic w_bus_wait;
  logic w_mem_ack;
  logic w_bus_done;

  assign w_mem_op   = iMemRead | iMemWrite;
  assign w_bus_wait = iBustoReg & ~iBusValid;
  assign w_mem_ack  = (r_state == MEM_WAIT) & iMemAck;
  assign w_bus_done = (r_state == BUS_WAIT) & iBusValid;

  // COMPLETE releases upstream: the stalled instruction retires here.
  always_comb begin
    oStall = 1'b0;
    case (r_state)
      IDLE:               oStall = w_mem_op | w_bus_wait;
      MEM_WAIT, BUS_WAIT: oStall = 1'b1;
      default:            oStall = 1'b0;
    endcase
  end

  assign oForward = {oRegWe && (oRegDest == iSr2), oRegWe && (oRegDest == iSr1)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_dest         <= '0;
      r_load_wb      <= 1'b0;
      oMemReq        <= 1'b0;
      oMemWe         <= 1'b0;
      oMemAddr       <= '0;
      oMemWData      <= '0;
      oRegWe         <= 1'b0;
      oRegDest       <= '0;
      oWriteBackData <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            oMemAddr  <= iAluOut;
            oMemWData <= iData2;
            r_dest    <= iDest;
            // read+write together behaves as a plain store
            r_load_wb <= iMemRead & ~iMemWrite & iMemtoReg;
            oMemReq   <= 1'b1;
            oMemWe    <= iMemWrite;
            oRegWe    <= 1'b0;
            r_state   <= MEM_WAIT;
          end else if (iBustoReg) begin
            if (iBusValid) begin
              oWriteBackData <= iBusData;
              oRegDest       <= iDest;
              oRegWe         <= 1'b1;
            end else begin
              r_dest  <= iDest;
              oRegWe  <= 1'b0;
              r_state <= BUS_WAIT;
            end
          end else if (iAlutoReg) begin
            oWriteBackData <= iAluOut;
            oRegDest       <= iDest;
            oRegWe         <= 1'b1;
          end else begin
            oRegWe <= 1'b0;
          end
        end
        MEM_WAIT: begin
          oRegWe <= 1'b0;
          if (w_mem_ack) begin
            oMemReq <= 1'b0;
            if (r_load_wb) begin
              oWriteBackData <= iMemRData;
              oRegDest       <= r_dest;
              oRegWe         <= 1'b1;
            end
            r_state <= COMPLETE;
          end
        end
        BUS_WAIT: begin
          oRegWe <= 1'b0;
          if (w_bus_done) begin
            oWriteBackData <= iBusData;
            oRegDest       <= r_dest;
            oRegWe         <= 1'b1;
            r_state        <= COMPLETE;
          end
        end
        COMPLETE: begin
          oRegWe  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// tb/tb_mem_writeback.sv - scoreboard bench for mem_writeback with random instruction stream
module tb_mem_writeback;

  localparam int K_NOP = 0, K_ALU = 1, K_LD = 2, K_LDN = 3, K_ST = 4, K_RW = 5, K_BUS = 6;

  typedef struct {
    int          kind;
    logic [15:0] alu;
    logic [15:0] d2;
    logic [15:0] bus;
    logic [3:0]  dest;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    int          dly;
  } instr_t;

  typedef struct {
    int          cyc;
    logic [3:0]  dest;
    logic [15:0] data;
  } wb_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        wb;
    logic [3:0]  dest;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] iAluOut, iData2, iMemRData, iBusData;
  logic [3:0]  iDest, iSr1, iSr2;
  logic        iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iMemAck, iBusValid;
  logic [1:0]  oForward;
  logic        oStall, oMemReq, oMemWe, oRegWe;
  logic [15:0] oMemAddr, oMemWData, oWriteBackData;
  logic [3:0]  oRegDest;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = -10;
  int forced_dly = -1;
  bit hold_ack = 0;
  bit force_stray = 0;
  bit mon_en = 0;
  wb_t  wb_q[$];
  mem_t mem_q[$];

  mem_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .iAluOut(iAluOut), .iData2(iData2), .iDest(iDest),
    .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
    .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iSr1(iSr1), .iSr2(iSr2),
    .oForward(oForward), .oStall(oStall), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .iBusData(iBusData), .iBusValid(iBusValid), .oRegWe(oRegWe), .oRegDest(oRegDest),
    .oWriteBackData(oWriteBackData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rom(input logic [15:0] a);
    if (a == 16'h0040) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h1357;
  endfunction

  function automatic instr_t mk(input int kind, input logic [15:0] alu, input logic [15:0] d2,
                                input logic [15:0] bus, input logic [3:0] dest,
                                input logic [3:0] sr1, input logic [3:0] sr2, input int dly);
    instr_t t;
    t.kind = kind; t.alu = alu; t.d2 = d2; t.bus = bus;
    t.dest = dest; t.sr1 = sr1; t.sr2 = sr2; t.dly = dly;
    return t;
  endfunction

  // Presents one instruction the way the upstream pipeline would: held while stalled.
  task automatic issue(input instr_t t);
    int   k;
    bit   done;
    bit   is_mem;
    logic s;
    logic exp_s;
    mem_t m;
    wb_t  w;
    k = 0;
    done = 0;
    is_mem = (t.kind == K_LD || t.kind == K_LDN || t.kind == K_ST || t.kind == K_RW);
    iAluOut = t.alu; iData2 = t.d2; iDest = t.dest; iSr1 = t.sr1; iSr2 = t.sr2;
    iAlutoReg = (t.kind == K_ALU);
    iBustoReg = (t.kind == K_BUS);
    iMemRead  = (t.kind == K_LD || t.kind == K_LDN || t.kind == K_RW);
    iMemWrite = (t.kind == K_ST || t.kind == K_RW);
    iMemtoReg = (t.kind == K_LD || t.kind == K_RW);
    if (is_mem) begin
      m.addr = t.alu; m.we = iMemWrite; m.wdata = t.d2; m.wb = (t.kind == K_LD); m.dest = t.dest;
      mem_q.push_back(m);
    end
    if (t.kind == K_ALU) begin
      w.cyc = cyc + 1; w.dest = t.dest; w.data = t.alu;
      wb_q.push_back(w);
    end
    while (!done) begin
      if (t.kind == K_BUS && k <= t.dly) begin
        iBusValid = (k == t.dly);
        iBusData  = (k == t.dly) ? t.bus : 16'($urandom);
        if (k == t.dly) begin
          w.cyc = cyc + 1; w.dest = t.dest; w.data = t.bus;
          wb_q.push_back(w);
        end
      end else begin
        iBusValid = 1'($urandom_range(0, 1));
        iBusData  = 16'($urandom);
      end
      @(negedge clk);
      if (is_mem)              exp_s = !(ack_cyc == cyc - 1);
      else if (t.kind == K_BUS) exp_s = (k <= t.dly) && (t.dly != 0);
      else                     exp_s = 1'b0;
      s = oStall;
      check("stall", s, exp_s);
      @(posedge clk); #1;
      k++;
      if (!s) done = 1;
      else if (k >= 40) begin
        checks++; errors++;
        $display("FAIL issue_timeout actual=%0d cycles required=release", k);
        done = 1;
      end
    end
  endtask

  // Memory responder: checks each new request against the expected access, then acks.
  initial begin : responder
    bit   serving;
    int   wait_left;
    mem_t cur;
    wb_t  w;
    serving = 0; wait_left = 0;
    iMemAck = 1'b0; iMemRData = '0;
    forever begin
      @(posedge clk); #1;
      iMemAck = 1'b0;
      iMemRData = 16'($urandom);
      if (!rst_n || !oMemReq) begin
        serving = 0;
        if (rst_n && (force_stray || $urandom_range(0, 7) == 0)) iMemAck = 1'b1;
      end else begin
        if (!serving) begin
          serving = 1;
          wait_left = (forced_dly >= 0) ? forced_dly : $urandom_range(0, 3);
          if (mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req actual=req addr %0h required=no request", oMemAddr);
            cur.addr = oMemAddr; cur.we = 1'b1; cur.wdata = '0; cur.wb = 1'b0; cur.dest = '0;
          end else begin
            cur = mem_q.pop_front();
            check("mem_addr", oMemAddr, cur.addr);
            check("mem_we", oMemWe, cur.we);
            check("mem_wdata", oMemWData, cur.wdata);
          end
        end
        if (!hold_ack) begin
          if (wait_left == 0) begin
            iMemAck = 1'b1;
            if (!cur.we) iMemRData = rom(cur.addr);
            ack_cyc = cyc;
            if (cur.wb) begin
              w.cyc = cyc + 1; w.dest = cur.dest; w.data = rom(cur.addr);
              wb_q.push_back(w);
            end
            serving = 0;
          end else begin
            wait_left--;
          end
        end
      end
    end
  end

  // Write-back monitor: oRegWe must pulse exactly in the predicted cycles.
  always @(negedge clk) begin : monitor
    wb_t e;
    if (rst_n && mon_en) begin
      while (wb_q.size() > 0 && wb_q[0].cyc < cyc) begin
        e = wb_q.pop_front();
        checks++; errors++;
        $display("FAIL missed_write actual=none required=dest %0h data %0h", e.dest, e.data);
      end
      if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
        e = wb_q.pop_front();
        check("reg_we", oRegWe, 1'b1);
        check("reg_dest", oRegDest, e.dest);
        check("wb_data", oWriteBackData, e.data);
        check("forward", oForward, {iSr2 == e.dest, iSr1 == e.dest});
      end else begin
        check("reg_we_idle", oRegWe, 1'b0);
        check("forward_idle", oForward, 2'b00);
      end
    end
  end

  initial begin : stimulus
    instr_t t;
    rst_n = 1'b0;
    iAluOut = '0; iData2 = '0; iDest = '0; iSr1 = '0; iSr2 = '0; iBusData = '0;
    iAlutoReg = 0; iMemtoReg = 0; iBustoReg = 0; iMemRead = 0; iMemWrite = 0; iBusValid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_memreq", oMemReq, 1'b0);
    check("rst_memwe", oMemWe, 1'b0);
    check("rst_memaddr", oMemAddr, 16'h0);
    check("rst_memwdata", oMemWData, 16'h0);
    check("rst_regwe", oRegWe, 1'b0);
    check("rst_regdest", oRegDest, 4'h0);
    check("rst_wbdata", oWriteBackData, 16'h0);
    check("rst_stall", oStall, 1'b0);
    check("rst_forward", oForward, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;

    issue(mk(K_ALU, 16'h1234, 16'h0, 16'h0, 4'd5, 4'd1, 4'd2, 0));
    issue(mk(K_NOP, 16'h0, 16'h0, 16'h0, 4'd0, 4'd5, 4'd9, 0));
    forced_dly = 2;
    issue(mk(K_LD, 16'h0040, 16'h0, 16'h0, 4'd6, 4'd0, 4'd0, 0));
    forced_dly = 0;
    issue(mk(K_ST, 16'h0010, 16'hA5A5, 16'h0, 4'd7, 4'd6, 4'd6, 0));
    forced_dly = -1;
    issue(mk(K_BUS, 16'h0, 16'h0, 16'h00FF, 4'd8, 4'd0, 4'd0, 2));
    issue(mk(K_ALU, 16'h0333, 16'h0, 16'h0, 4'd3, 4'd8, 4'd8, 0));
    issue(mk(K_ALU, 16'h0444, 16'h0, 16'h0, 4'd3, 4'd3, 4'd3, 0));
    issue(mk(K_NOP, 16'h0, 16'h0, 16'h0, 4'd0, 4'd2, 4'd4, 0));

    for (int i = 0; i < 250; i++) begin
      t = mk($urandom_range(0, 6), 16'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
      issue(t);
    end
    issue(mk(K_NOP, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0, 0));

    // Reset in the middle of an outstanding load.
    hold_ack = 1;
    iBusValid = 0; iAlutoReg = 0; iBustoReg = 0; iMemWrite = 0;
    iMemRead = 1; iMemtoReg = 1; iAluOut = 16'h0080; iData2 = 16'h1111; iDest = 4'd7;
    mem_q.push_back('{addr: 16'h0080, we: 1'b0, wdata: 16'h1111, wb: 1'b1, dest: 4'd7});
    @(posedge clk); #1;
    check("mw_memreq", oMemReq, 1'b1);
    check("mw_stall", oStall, 1'b1);
    @(negedge clk);
    iMemRead = 0; iMemtoReg = 0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_memreq", oMemReq, 1'b0);
    check("rst_mid_regwe", oRegWe, 1'b0);
    check("rst_mid_stall", oStall, 1'b0);
    mem_q.delete();
    wb_q.delete();
    hold_ack = 0;
    force_stray = 1;
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("post_rst_memreq", oMemReq, 1'b0);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
